// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock.
// In signed mode the magnitude is converted and the sign is reported on Neg.
module bin2bcd_seq #(
   parameter int W      = 32,
   parameter int DIGITS = 10,
   parameter int SIGNED = 0
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                Start,
   input  logic [W-1:0]        Bin,
   output logic                Busy,
   output logic                Done,
   output logic [4*DIGITS-1:0] Bcd,
   output logic                Neg,
   output logic                Ovf
);
   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * DIGITS;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nxt;
   logic [W-1:0] mag;
   logic [BW-1:0] dig, adj, dig_sh;
   logic [CW-1:0] cnt;
   logic sticky, sign, last, in_neg, lost;
   always_comb begin
      in_neg = (SIGNED != 0) && Bin[W-1];
      last = cnt == CW'(W - 1);
      adj = dig;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i+:4] = (dig[4*i+:4] >= 4'd5) ? dig[4*i+:4] + 4'd3 : dig[4*i+:4];
      dig_sh = {adj[BW-2:0], mag[W-1]};
      lost = adj[BW-1];
      state_nxt = (state == IDLE) ? (Start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
   end
   assign Busy = state == SHIFT;
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) state <= IDLE;
      else state <= state_nxt;
   // Bcd/Neg/Ovf are only written on the final shift so partial results never show.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         mag <= '0;
         dig <= '0;
         cnt <= '0;
         sticky <= 1'b0;
         sign <= 1'b0;
         Done <= 1'b0;
         Bcd <= '0;
         Neg <= 1'b0;
         Ovf <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (state == IDLE) begin
            if (Start) begin
               mag <= in_neg ? -Bin : Bin;
               sign <= in_neg;
               dig <= '0;
               sticky <= 1'b0;
               cnt <= '0;
            end
         end else begin
            mag <= {mag[W-2:0], 1'b0};
            dig <= dig_sh;
            sticky <= sticky | lost;
            cnt <= cnt + CW'(1);
            if (last) begin
               Bcd <= dig_sh;
               Neg <= sign;
               Ovf <= sticky | lost;
               Done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench over unsigned, signed and 4-digit converter instances.
module tb_bin2bcd_seq;
   typedef struct {
      int          id;
      logic [39:0] bcd;
      logic        neg;
      logic        ovf;
      int          due;
   } ent_t;
   logic clk, rst_n;
   logic [2:0] st, bsy, dn, ng, ov;
   logic [31:0] bin [3];
   logic [39:0] bcd0, bcd1;
   logic [15:0] bcd2;
   ent_t q[$];
   int cyc = 0, checks = 0, errors = 0;

   bin2bcd_seq #(.W(32), .DIGITS(10), .SIGNED(0)) u_uns (
      .Clk(clk), .Rst_n(rst_n), .Start(st[0]), .Bin(bin[0]), .Busy(bsy[0]),
      .Done(dn[0]), .Bcd(bcd0), .Neg(ng[0]), .Ovf(ov[0]));
   bin2bcd_seq #(.W(32), .DIGITS(10), .SIGNED(1)) u_sgn (
      .Clk(clk), .Rst_n(rst_n), .Start(st[1]), .Bin(bin[1]), .Busy(bsy[1]),
      .Done(dn[1]), .Bcd(bcd1), .Neg(ng[1]), .Ovf(ov[1]));
   bin2bcd_seq #(.W(16), .DIGITS(4), .SIGNED(0)) u_d4 (
      .Clk(clk), .Rst_n(rst_n), .Start(st[2]), .Bin(bin[2][15:0]), .Busy(bsy[2]),
      .Done(dn[2]), .Bcd(bcd2), .Neg(ng[2]), .Ovf(ov[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic mon(input int id, input logic [39:0] b, input logic n, input logic o, input logic bz);
      int idx = -1;
      ent_t e;
      foreach (q[i]) if (idx < 0 && q[i].id == id) idx = i;
      checks++;
      if (idx < 0) begin
         errors++;
         $display("FAIL unexpected_done dut%0d bcd=%h cyc=%0d", id, b, cyc);
      end else begin
         e = q[idx];
         q.delete(idx);
         if (b !== e.bcd || n !== e.neg || o !== e.ovf || bz !== 1'b0 || cyc != e.due) begin
            errors++;
            $display("FAIL result dut%0d got bcd=%h neg=%b ovf=%b busy=%b cyc=%0d expected bcd=%h neg=%b ovf=%b busy=0 cyc=%0d",
                     id, b, n, o, bz, cyc, e.bcd, e.neg, e.ovf, e.due);
         end
      end
   endtask

   always @(negedge clk) begin
      if (dn[0]) mon(0, bcd0, ng[0], ov[0], bsy[0]);
      if (dn[1]) mon(1, bcd1, ng[1], ov[1], bsy[1]);
      if (dn[2]) mon(2, {24'd0, bcd2}, ng[2], ov[2], bsy[2]);
   end

   task automatic drain();
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL timeout pending=%0d required=0", q.size());
         q.delete();
      end
   endtask

   // Called right after a falling edge; the accepting edge is the next rising edge.
   task automatic issue(input int id, input logic [31:0] b, input logic [39:0] eb, input logic en, input logic eo);
      st[id] = 1'b1;
      bin[id] = b;
      q.push_back('{id, eb, en, eo, cyc + ((id == 2) ? 16 : 32) + 1});
      @(negedge clk);
      st[id] = 1'b0;
      chk("busy_running", {39'd0, bsy[id]}, 40'd1);
      drain();
   endtask

   initial begin
      rst_n = 1'b0;
      st = '0;
      foreach (bin[i]) bin[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {37'd0, bsy}, 40'd0);
      chk("rst_done", {37'd0, dn}, 40'd0);
      chk("rst_bcd0", bcd0, 40'd0);
      chk("rst_bcd2", {24'd0, bcd2}, 40'd0);
      chk("rst_neg_ovf", {34'd0, ng, ov}, 40'd0);
      rst_n = 1'b1;
      @(negedge clk);
      issue(0, 32'd0, 40'h0, 1'b0, 1'b0);
      issue(0, 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0, 1'b0);
      issue(0, 32'd100, 40'h100, 1'b0, 1'b0);
      issue(1, 32'hFFFF_F617, 40'h2537, 1'b1, 1'b0);
      issue(1, 32'h8000_0000, 40'h21_4748_3648, 1'b1, 1'b0);
      issue(1, 32'd2537, 40'h2537, 1'b0, 1'b0);
      issue(1, 32'h7FFF_FFFF, 40'h21_4748_3647, 1'b0, 1'b0);
      issue(2, 32'd12345, 40'h2345, 1'b0, 1'b1);
      issue(2, 32'd9999, 40'h9999, 1'b0, 1'b0);
      issue(2, 32'd65535, 40'h5535, 1'b0, 1'b1);
      issue(2, 32'd0, 40'h0, 1'b0, 1'b0);
      // Start held through Busy and the Done cycle: 1234 then 99 back-to-back.
      st[0] = 1'b1;
      bin[0] = 32'd1234;
      q.push_back('{0, 40'h1234, 1'b0, 1'b0, cyc + 33});
      q.push_back('{0, 40'h99, 1'b0, 1'b0, cyc + 66});
      repeat (5) @(negedge clk);
      bin[0] = 32'd99;
      repeat (29) @(negedge clk);
      st[0] = 1'b0;
      drain();
      // Reset at clock 10 of a conversion aborts it silently.
      st[0] = 1'b1;
      bin[0] = 32'd5678;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {39'd0, bsy[0]}, 40'd0);
      chk("abort_bcd", bcd0, 40'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("abort_no_done_bcd", bcd0, 40'd0);
      issue(0, 32'd5678, 40'h5678, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
